// File: rtl/mipse.sv
// Five-stage MIPS subset pipeline (IF/ID/EX/MEM/WB) with hazard control.
// Define MIPSE_FORWARD_EN to enable EX-operand forwarding; otherwise ID stalls on pending writes.
module mipse #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] readdata,
  output logic [31:0] pc,
  output logic [31:0] aluout,
  output logic [31:0] writedata,
  output logic        memwrite
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       bne;
    logic       alu_imm;
    alu_op_e    alu_op;
    logic [4:0] dst;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  logic [31:0] r_pc, r_d_instr, r_d_pc4;
  ctrl_t       r_e_ctrl;
  logic [31:0] r_e_a, r_e_b, r_e_imm, r_e_pc4;
  logic        r_m_reg_write, r_m_mem_read, r_m_mem_write;
  logic [4:0]  r_m_dst;
  logic [31:0] r_m_alu, r_m_wd;
  logic        r_w_reg_write;
  logic [4:0]  r_w_dst;
  logic [31:0] r_w_data;
  logic [31:0] r_rf [32];

  logic [4:0]  w_rs, w_rt;
  logic [31:0] w_rs_val, w_rt_val, w_imm, w_jtarget;
  ctrl_t       w_ctrl;
  logic        w_use_rs, w_use_rt, w_jump, w_rtype_ok;
  logic [31:0] w_fa, w_fb, w_srcb, w_alu, w_btarget;
  logic        w_taken, w_hit_e, w_hazard;
  logic        stall;

  assign w_rs      = r_d_instr[25:21];
  assign w_rt      = r_d_instr[20:16];
  assign w_jtarget = {r_d_pc4[31:28], r_d_instr[25:0], 2'b00};

  // NOTE: every output of a combinational block is defaulted first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_ctrl     = CTRL_NOP;
    w_imm      = {{16{r_d_instr[15]}}, r_d_instr[15:0]};
    w_use_rs   = 1'b0;
    w_use_rt   = 1'b0;
    w_jump     = 1'b0;
    w_rtype_ok = 1'b0;
    case (r_d_instr[31:26])
      6'h00: begin
        w_rtype_ok = 1'b1;
        case (r_d_instr[5:0])
          6'h20:   w_ctrl.alu_op = ALU_ADD;
          6'h22:   w_ctrl.alu_op = ALU_SUB;
          6'h24:   w_ctrl.alu_op = ALU_AND;
          6'h25:   w_ctrl.alu_op = ALU_OR;
          6'h2a:   w_ctrl.alu_op = ALU_SLT;
          default: w_rtype_ok    = 1'b0;
        endcase
        if (w_rtype_ok) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.dst       = r_d_instr[15:11];
          w_use_rs         = 1'b1;
          w_use_rt         = 1'b1;
        end
      end
      6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h23: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_imm   = 1'b1;
        w_ctrl.dst       = w_rt;
        w_use_rs         = (r_d_instr[31:26] != 6'h0f);
        w_ctrl.mem_read  = (r_d_instr[31:26] == 6'h23);
        case (r_d_instr[31:26])
          6'h0a:   w_ctrl.alu_op = ALU_SLT;
          6'h0c:   w_ctrl.alu_op = ALU_AND;
          6'h0d:   w_ctrl.alu_op = ALU_OR;
          6'h0f:   w_ctrl.alu_op = ALU_LUI;
          default: w_ctrl.alu_op = ALU_ADD;
        endcase
        if (r_d_instr[31:26] inside {6'h0c, 6'h0d, 6'h0f})
          w_imm = {16'h0, r_d_instr[15:0]};
      end
      6'h2b: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_imm   = 1'b1;
        w_use_rs         = 1'b1;
        w_use_rt         = 1'b1;
      end
      6'h04, 6'h05: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.bne    = r_d_instr[26];
        w_use_rs      = 1'b1;
        w_use_rt      = 1'b1;
      end
      6'h02:   w_jump = 1'b1;
      default: ;
    endcase
  end

  // Register read sees the value being written back this same cycle.
  assign w_rs_val = (w_rs == 5'd0) ? 32'h0 :
                    (r_w_reg_write && r_w_dst == w_rs) ? r_w_data : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'h0 :
                    (r_w_reg_write && r_w_dst == w_rt) ? r_w_data : r_rf[w_rt];

  assign w_hit_e = r_e_ctrl.reg_write && r_e_ctrl.dst != 5'd0 &&
                   ((w_use_rs && w_rs == r_e_ctrl.dst) || (w_use_rt && w_rt == r_e_ctrl.dst));

`ifdef MIPSE_FORWARD_EN
  logic [4:0] r_e_rs, r_e_rt;

  assign w_fa = (r_m_reg_write && r_m_dst != 5'd0 && r_m_dst == r_e_rs) ? r_m_alu :
                (r_w_reg_write && r_w_dst != 5'd0 && r_w_dst == r_e_rs) ? r_w_data : r_e_a;
  assign w_fb = (r_m_reg_write && r_m_dst != 5'd0 && r_m_dst == r_e_rt) ? r_m_alu :
                (r_w_reg_write && r_w_dst != 5'd0 && r_w_dst == r_e_rt) ? r_w_data : r_e_b;
  assign w_hazard = w_hit_e && r_e_ctrl.mem_read;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_e_rs <= '0;
      r_e_rt <= '0;
    end else begin
      r_e_rs <= w_rs;
      r_e_rt <= w_rt;
    end
  end
`else
  assign w_fa = r_e_a;
  assign w_fb = r_e_b;
  assign w_hazard = w_hit_e ||
                    (r_m_reg_write && r_m_dst != 5'd0 &&
                     ((w_use_rs && w_rs == r_m_dst) || (w_use_rt && w_rt == r_m_dst)));
`endif

  assign w_srcb    = r_e_ctrl.alu_imm ? r_e_imm : w_fb;
  assign w_taken   = r_e_ctrl.branch && ((w_fa == w_fb) ^ r_e_ctrl.bne);
  assign w_btarget = r_e_pc4 + {r_e_imm[29:0], 2'b00};
  // A taken branch flushes the instruction that would have stalled.
  assign stall     = w_hazard && !w_taken;

  always_comb begin
    w_alu = '0;
    case (r_e_ctrl.alu_op)
      ALU_ADD: w_alu = w_fa + w_srcb;
      ALU_SUB: w_alu = w_fa - w_srcb;
      ALU_AND: w_alu = w_fa & w_srcb;
      ALU_OR:  w_alu = w_fa | w_srcb;
      ALU_SLT: w_alu = {31'h0, $signed(w_fa) < $signed(w_srcb)};
      ALU_LUI: w_alu = {w_srcb[15:0], 16'h0};
      default: w_alu = '0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every stage samples the previous cycle's values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pc          <= RESET_PC;
      r_d_instr     <= '0;
      r_d_pc4       <= '0;
      r_e_ctrl      <= CTRL_NOP;
      r_e_a         <= '0;
      r_e_b         <= '0;
      r_e_imm       <= '0;
      r_e_pc4       <= '0;
      r_m_reg_write <= 1'b0;
      r_m_mem_read  <= 1'b0;
      r_m_mem_write <= 1'b0;
      r_m_dst       <= '0;
      r_m_alu       <= '0;
      r_m_wd        <= '0;
      r_w_reg_write <= 1'b0;
      r_w_dst       <= '0;
      r_w_data      <= '0;
      // NOTE: the register file is cleared on reset because its architectural reset state is all zeros.
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      if (w_taken)      r_pc <= w_btarget;
      else if (!stall)  r_pc <= w_jump ? w_jtarget : r_pc + 32'd4;

      if (w_taken || w_jump) begin
        r_d_instr <= '0;
      end else if (!stall) begin
        r_d_instr <= instr;
        r_d_pc4   <= r_pc + 32'd4;
      end

      r_e_ctrl <= (w_taken || stall) ? CTRL_NOP : w_ctrl;
      r_e_a    <= w_rs_val;
      r_e_b    <= w_rt_val;
      r_e_imm  <= w_imm;
      r_e_pc4  <= r_d_pc4;

      r_m_reg_write <= r_e_ctrl.reg_write;
      r_m_mem_read  <= r_e_ctrl.mem_read;
      r_m_mem_write <= r_e_ctrl.mem_write;
      r_m_dst       <= r_e_ctrl.dst;
      r_m_alu       <= w_alu;
      r_m_wd        <= w_fb;

      r_w_reg_write <= r_m_reg_write;
      r_w_dst       <= r_m_dst;
      r_w_data      <= r_m_mem_read ? readdata : r_m_alu;

      if (r_w_reg_write && r_w_dst != 5'd0) r_rf[r_w_dst] <= r_w_data;
    end
  end

  assign pc        = r_pc;
  assign aluout    = r_m_alu;
  assign writedata = r_m_wd;
  assign memwrite  = r_m_mem_write;

endmodule

// File: tb/tb_mipse.sv
// Self-checking bench for mipse: short programs with expected register results and stall counts.
module tb_mipse;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, readdata, pc, aluout, writedata;
  logic        memwrite;
  logic [31:0] imem [64];
  logic [31:0] dmem [1024];
  logic        dmem_init;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign instr    = imem[pc[7:2]];
  assign readdata = dmem[aluout[11:2]];

  always @(posedge clk) begin
    if (dmem_init) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= '0;
      dmem[0] <= 32'h0000_1234;
    end else if (memwrite) begin
      dmem[aluout[11:2]] <= writedata;
    end
  end

  mipse dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .readdata  (readdata),
    .pc        (pc),
    .aluout    (aluout),
    .writedata (writedata),
    .memwrite  (memwrite)
  );

  typedef struct packed {
    logic [3:0][31:0] prog;
    logic [4:0]       rg;
    logic [31:0]      exp;
    logic [3:0]       st_f;
    logic [3:0]       st_n;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  int   nv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rt_op(input logic [5:0] f, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'h00, f};
  endfunction

  function automatic logic [31:0] it_op(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic add_vec(input logic [31:0] p0, p1, p2, p3, input logic [4:0] rg,
                         input logic [31:0] exp, input int sf, input int sn);
    vecs[nv].prog[0] = p0;
    vecs[nv].prog[1] = p1;
    vecs[nv].prog[2] = p2;
    vecs[nv].prog[3] = p3;
    vecs[nv].rg      = rg;
    vecs[nv].exp     = exp;
    vecs[nv].st_f    = 4'(sf);
    vecs[nv].st_n    = 4'(sn);
    nv++;
  endtask

  task automatic load_prog(input logic [3:0][31:0] p);
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 4; i++) imem[i] = p[i];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    dmem_init = 1'b1;
    repeat (2) @(negedge clk);
    rst_n     = 1'b0;
    dmem_init = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   st, exp_st;
    v = vecs[idx];
    load_prog(v.prog);
    apply_reset();
    st = 0;
    repeat (24) begin
      @(negedge clk);
      if (dut.stall) st++;
    end
`ifdef MIPSE_FORWARD_EN
    exp_st = int'(v.st_f);
`else
    exp_st = int'(v.st_n);
`endif
    check($sformatf("vec%0d r%0d", idx, v.rg), dut.r_rf[v.rg], v.exp);
    check($sformatf("vec%0d stalls", idx), 32'(st), 32'(exp_st));
  endtask

  localparam logic [31:0] NOP = 32'h0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mw_cnt;
    logic [31:0] mw_addr, mw_data;
    logic seen_tgt;

    rst_n     = 1'b1;
    dmem_init = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;

    add_vec(it_op(6'h08,0,1,16'd5), it_op(6'h08,1,2,16'd3), NOP, NOP, 5'd2, 32'd8, 0, 2);
    add_vec(it_op(6'h23,0,3,16'd0), rt_op(6'h20,3,3,4), NOP, NOP, 5'd4, 32'h2468, 1, 2);
    add_vec(it_op(6'h08,0,1,16'd3), it_op(6'h08,0,2,16'd10), rt_op(6'h22,1,2,3), NOP,
            5'd3, 32'hffff_fff9, 0, 2);
    add_vec(it_op(6'h08,0,1,16'hffff), it_op(6'h0a,1,2,16'd1), NOP, NOP, 5'd2, 32'd1, 0, 2);
    add_vec(it_op(6'h08,0,1,16'hffff), rt_op(6'h2a,0,1,3), NOP, NOP, 5'd3, 32'd0, 0, 2);
    add_vec(it_op(6'h08,0,1,16'hffff), it_op(6'h0c,1,2,16'h8000), NOP, NOP,
            5'd2, 32'h0000_8000, 0, 2);
    add_vec(it_op(6'h08,0,1,16'h0ff0), it_op(6'h08,0,2,16'h00ff), rt_op(6'h24,1,2,3), NOP,
            5'd3, 32'h0000_00f0, 0, 2);
    add_vec(it_op(6'h08,0,1,16'h0ff0), it_op(6'h08,0,2,16'h00ff), rt_op(6'h25,1,2,3), NOP,
            5'd3, 32'h0000_0fff, 0, 2);
    add_vec(it_op(6'h0f,0,1,16'h1234), it_op(6'h0d,1,1,16'h5678), NOP, NOP,
            5'd1, 32'h1234_5678, 0, 2);
    add_vec(it_op(6'h0f,0,1,16'h7fff), it_op(6'h0d,1,1,16'hffff), rt_op(6'h20,1,1,2), NOP,
            5'd2, 32'hffff_fffe, 0, 4);
    add_vec(it_op(6'h08,0,1,16'h8000), NOP, NOP, NOP, 5'd1, 32'hffff_8000, 0, 0);
    add_vec(it_op(6'h08,0,1,16'd7), it_op(6'h3f,0,1,16'd9), rt_op(6'h21,0,0,1), NOP,
            5'd1, 32'd7, 0, 0);
    add_vec(it_op(6'h08,0,0,16'd5), rt_op(6'h20,0,0,1), NOP, NOP, 5'd1, 32'd0, 0, 0);
    add_vec(it_op(6'h04,0,0,16'd2), it_op(6'h08,0,5,16'd1), it_op(6'h08,0,5,16'd2),
            it_op(6'h08,0,7,16'd3), 5'd5, 32'd0, 0, 0);
    add_vec(it_op(6'h04,0,0,16'd2), it_op(6'h08,0,5,16'd1), it_op(6'h08,0,5,16'd2),
            it_op(6'h08,0,7,16'd3), 5'd7, 32'd3, 0, 0);
    add_vec(it_op(6'h08,0,1,16'd1), it_op(6'h05,1,0,16'd1), it_op(6'h08,0,5,16'd4),
            it_op(6'h08,0,6,16'd6), 5'd5, 32'd0, 0, 2);
    add_vec(it_op(6'h08,0,1,16'd1), it_op(6'h05,1,0,16'd1), it_op(6'h08,0,5,16'd4),
            it_op(6'h08,0,6,16'd6), 5'd6, 32'd6, 0, 2);
    add_vec(it_op(6'h05,0,0,16'd1), it_op(6'h08,0,5,16'd4), NOP, NOP, 5'd5, 32'd4, 0, 0);
    add_vec({6'h02, 26'd3}, it_op(6'h08,0,5,16'd1), it_op(6'h08,0,5,16'd2),
            it_op(6'h08,0,6,16'd9), 5'd5, 32'd0, 0, 0);
    add_vec({6'h02, 26'd3}, it_op(6'h08,0,5,16'd1), it_op(6'h08,0,5,16'd2),
            it_op(6'h08,0,6,16'd9), 5'd6, 32'd9, 0, 0);
    add_vec(it_op(6'h08,0,1,16'h0055), it_op(6'h2b,0,1,16'd8), it_op(6'h23,0,2,16'd8), NOP,
            5'd2, 32'h0000_0055, 0, 2);
    add_vec(it_op(6'h08,0,1,16'd1), it_op(6'h04,0,0,16'd1), rt_op(6'h20,1,1,2),
            it_op(6'h08,0,3,16'd7), 5'd2, 32'd0, 0, 0);
    add_vec(it_op(6'h08,0,1,16'd1), it_op(6'h04,0,0,16'd1), rt_op(6'h20,1,1,2),
            it_op(6'h08,0,3,16'd7), 5'd3, 32'd7, 0, 0);

    // Reset state with nothing run yet.
    repeat (2) @(negedge clk);
    check("reset pc", pc, 32'h0);
    check("reset memwrite", 32'(memwrite), 32'h0);
    check("reset aluout", aluout, 32'h0);
    check("reset writedata", writedata, 32'h0);
    check("reset stall", 32'(dut.stall), 32'h0);

    for (int i = 0; i < nv; i++) run_vec(i);

    // Asynchronous reset clears pc and registers at once, without waiting for a clock.
    run_vec(0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async reset pc", pc, 32'h0);
    check("async reset r1", dut.r_rf[1], 32'h0);
    check("async reset r2", dut.r_rf[2], 32'h0);
    rst_n = 1'b0;

    // Unaligned store address passes through; store data is the forwarded rt.
    load_prog({NOP, it_op(6'h2b,6,1,16'd0), it_op(6'h08,0,6,16'h7fff), it_op(6'h08,0,1,16'd5)});
    apply_reset();
    check("first fetch pc", pc, 32'h0);
    @(negedge clk);
    check("second fetch pc", pc, 32'h4);
    mw_cnt  = 0;
    mw_addr = '0;
    mw_data = '0;
    repeat (20) begin
      @(negedge clk);
      if (memwrite) begin
        mw_cnt++;
        mw_addr = aluout;
        mw_data = writedata;
      end
    end
    check("sw count", 32'(mw_cnt), 32'd1);
    check("sw aluout", mw_addr, 32'h0000_7fff);
    check("sw writedata", mw_data, 32'd5);
    check("sw dmem", dmem[10'h3ff], 32'd5);

    // Taken beq reaches its target address.
    load_prog({it_op(6'h08,0,7,16'd3), it_op(6'h08,0,5,16'd2), it_op(6'h08,0,5,16'd1),
               it_op(6'h04,0,0,16'd2)});
    apply_reset();
    seen_tgt = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pc == 32'd12) seen_tgt = 1'b1;
    end
    check("beq target seen", 32'(seen_tgt), 32'd1);

    // Reset pulse while a store sits in EX: the store never reaches memory.
    load_prog({NOP, NOP, NOP, it_op(6'h2b,0,0,16'd4)});
    apply_reset();
    mw_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    check("sw in EX pc", pc, 32'h8);
    rst_n   = 1'b1;
    imem[0] = NOP;
    #1;
    check("mid reset pc", pc, 32'h0);
    check("mid reset memwrite", 32'(memwrite), 32'h0);
    @(negedge clk);
    if (memwrite) mw_cnt++;
    rst_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (memwrite) mw_cnt++;
    end
    check("aborted sw memwrite", 32'(mw_cnt), 32'd0);
    check("aborted sw dmem", dmem[1], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mipse.md
MIPSE -- requirements
Module: mipse

Interface
REQ-001 RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-high (port name kept for codebase compatibility).
REQ-004 instr  input  32  instruction word fetched from address pc, combinational from instruction memory.
REQ-005 readdata  input  32  load data from data memory, combinational from aluout.
REQ-006 pc  output  32  IF-stage fetch address, byte address, word-aligned.
REQ-007 aluout  output  32  MEM-stage ALU result; data memory byte address for lw/sw.
REQ-008 writedata  output  32  MEM-stage store data (rt value, forwarded).
REQ-009 memwrite  output  1  high only while a sw occupies MEM; memory writes on the next rising edge.

Function
REQ-010 Pipeline SHALL be 5 stages: IF, ID, EX, MEM, WB; one instruction issued per cycle absent stalls/flushes.
REQ-011 ISA: R-type (op 0) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2a; addi 0x08, andi 0x0c, ori 0x0d, slti 0x0a, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, bne 0x05, j 0x02.
REQ-012 Any other opcode/funct SHALL execute as nop (no register write, memwrite 0).
REQ-013 Arithmetic SHALL be 32-bit wrap-around, no overflow trap; addi/slti/lw/sw/branch offsets sign-extended; andi/ori zero-extended; lui = imm<<16; slt/slti signed compare.
REQ-014 Register file: 32x32, r0 reads 0 and ignores writes; written at WB rising edge; same-cycle ID read of the WB register SHALL return the new value.
REQ-015 Forwarding SHALL route EX/MEM result, else MEM/WB result, to EX operands and to store data when the producing rd/rt is nonzero and matches.
REQ-016 Load-use: when EX holds lw with rt!=0 equal to ID rs or rt, PC and IF/ID SHALL hold, a bubble SHALL enter ID/EX, internal signal stall SHALL be 1 for that cycle.
REQ-017 beq/bne SHALL resolve in EX; target = PC+4 + (sext(imm)<<2); if taken, the two younger instructions in IF/ID and ID/EX SHALL be flushed (no delay slot).
REQ-018 j SHALL redirect in ID to {PC+4[31:28], imm26, 2'b00}, flushing the one instruction in IF.
REQ-019 Simultaneous taken branch in EX and stall: branch flush SHALL take priority; stall SHALL deassert.
REQ-020 aluout SHALL pass unaligned addresses unchanged (e.g. 32'h7fff); no alignment check.

Reset
REQ-021 While rst_n is high: pc=RESET_PC, all pipeline registers hold bubbles, memwrite=0, aluout=0, writedata=0, stall=0, all registers 0.
REQ-022 Reset asserted mid-operation SHALL abort all in-flight instructions immediately; no memory write SHALL occur on the following edge.
REQ-023 First fetch after release SHALL be from RESET_PC on the first rising edge.

Configuration
REQ-024 Macro MIPSE_FORWARD_EN defined: forwarding per REQ-015, stalls only per REQ-016.
REQ-025 MIPSE_FORWARD_EN undefined: no forwarding; ID SHALL stall (stall=1) while any nonzero source matches a pending write destination in EX or MEM; results architecturally identical.

Verification
REQ-026 Reset, then addi r1,r0,5; addi r2,r1,3 -> r2=8, stall never 1 (with MIPSE_FORWARD_EN).
REQ-027 lw r3,0(r0) with mem[0]=0x1234; add r4,r3,r3 -> exactly one stall cycle, r4=0x2468.
REQ-028 beq r0,r0,+2 followed by addi r5,r0,1 -> r5 stays 0, pc reaches target.
REQ-029 addi r6,r0,0x7fff; sw r1,0(r6) with r1=5 -> memwrite=1 with aluout=32'h7fff, writedata=5.
REQ-030 Assert rst_n for one cycle while sw is in EX -> memwrite never 1, pc returns to 0.
REQ-031 Without MIPSE_FORWARD_EN, sequence of REQ-026 -> r2=8 with two stall cycles.
